hazard_control_unit: RTL and testbench

Pipeline hazard controller that complements the forwarding unit: it handles every hazard forwarding cannot resolve by stalling, bubbling or flushing the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers load-use stalls, taken-branch/jump flushes, multi-cycle divide occupancy of EXE, and instruction/data memory busywait freezes. It also keeps saturating stall and flush counters for performance checks.

---
 rtl/hazard_control_unit_if.sv | 47 ++++
 rtl/hazard_control_unit.sv | 118 +++++++++++
 tb/tb_hazard_control_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The pipeline side (master) drives hazard sources; the unit (slave) drives register enables.
interface hazard_control_unit_if;
    // All signals are level-sensitive with no valid/ready handshake: the pipeline
    // registers sample the enables at every rising CLK.
    logic [4:0]  ADDR1;
    logic [4:0]  ADDR2;
    logic        RS1_USED;
    logic        RS2_USED;
    logic [6:0]  OPCODE;
    logic [4:0]  EXE_ADDR;
    logic        EXE_MEMREAD;
    logic        EXE_DIV;
    logic        BRANCH_TAKEN;
    logic        IMEM_BUSYWAIT;
    logic        DMEM_BUSYWAIT;

    logic        PC_WRITE;
    logic        IFID_WRITE;
    logic        IDEX_WRITE;
    logic        EXMEM_WRITE;
    logic        MEMWB_WRITE;
    logic        IFID_FLUSH;
    logic        IDEX_FLUSH;
    logic        IDEX_BUBBLE;
    logic        EXMEM_BUBBLE;
    logic        DIV_ACTIVE;
    logic        DBG_STATE;
    logic [15:0] STALL_COUNT;
    logic [15:0] FLUSH_COUNT;

    modport master (
        output ADDR1, ADDR2, RS1_USED, RS2_USED, OPCODE, EXE_ADDR, EXE_MEMREAD,
               EXE_DIV, BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        input  PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE,
               IFID_FLUSH, IDEX_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE, DIV_ACTIVE,
               DBG_STATE, STALL_COUNT, FLUSH_COUNT
    );

    modport slave (
        input  ADDR1, ADDR2, RS1_USED, RS2_USED, OPCODE, EXE_ADDR, EXE_MEMREAD,
               EXE_DIV, BRANCH_TAKEN, IMEM_BUSYWAIT, DMEM_BUSYWAIT,
        output PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE,
               IFID_FLUSH, IDEX_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE, DIV_ACTIVE,
               DBG_STATE, STALL_COUNT, FLUSH_COUNT
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: busywait freeze, branch flush, divide occupancy and
// load-use bubbles, with saturating stall/flush performance counters.
`ifndef STORE_OPCODE
`define STORE_OPCODE 7'b0100011
`endif

module hazard_control_unit #(
    parameter int DIV_CYCLES = 4
) (
    input logic                  CLK,
    input logic                  RESET,
    hazard_control_unit_if.slave hif
);
    typedef enum logic {RUN = 1'b0, DIV_WAIT = 1'b1} state_t;

    localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 2);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        busy;
    logic        load_use;
    logic        pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic        ifid_fl, idex_fl, idex_bub, exmem_bub;

    assign busy = hif.IMEM_BUSYWAIT | hif.DMEM_BUSYWAIT;

    // A store's rs2 is only store data, which is forwarded at MEM, so it never stalls.
    assign load_use = hif.EXE_MEMREAD && (hif.EXE_ADDR != 5'd0) &&
                      ((hif.RS1_USED && (hif.ADDR1 == hif.EXE_ADDR)) ||
                       (hif.RS2_USED && (hif.ADDR2 == hif.EXE_ADDR) &&
                        (hif.OPCODE != `STORE_OPCODE)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        idex_w    = 1'b1;
        exmem_w   = 1'b1;
        memwb_w   = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        idex_bub  = 1'b0;
        exmem_bub = 1'b0;
        if (!RESET || busy) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            memwb_w = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hif.BRANCH_TAKEN) begin
                        ifid_fl = 1'b1;
                        idex_fl = 1'b1;
                    end else if (hif.EXE_DIV) begin
                        pc_w      = 1'b0;
                        ifid_w    = 1'b0;
                        idex_w    = 1'b0;
                        exmem_bub = 1'b1;
                        state_d   = DIV_WAIT;
                        cnt_d     = CNT_INIT;
                    end else if (load_use) begin
                        pc_w     = 1'b0;
                        ifid_w   = 1'b0;
                        idex_bub = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (cnt_q != 6'd0) begin
                        pc_w      = 1'b0;
                        ifid_w    = 1'b0;
                        idex_w    = 1'b0;
                        exmem_bub = 1'b1;
                        cnt_d     = cnt_q - 6'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign stall_cnt_d = (!pc_w && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    assign flush_cnt_d = (ifid_fl && (flush_cnt_q != 16'hFFFF)) ? flush_cnt_q + 16'd1 : flush_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RUN;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.PC_WRITE     = pc_w;
    assign hif.IFID_WRITE   = ifid_w;
    assign hif.IDEX_WRITE   = idex_w;
    assign hif.EXMEM_WRITE  = exmem_w;
    assign hif.MEMWB_WRITE  = memwb_w;
    assign hif.IFID_FLUSH   = ifid_fl;
    assign hif.IDEX_FLUSH   = idex_fl;
    assign hif.IDEX_BUBBLE  = idex_bub;
    assign hif.EXMEM_BUBBLE = exmem_bub;
    assign hif.DIV_ACTIVE   = RESET && (state_q == DIV_WAIT);
    assign hif.DBG_STATE    = state_q;
    assign hif.STALL_COUNT  = stall_cnt_q;
    assign hif.FLUSH_COUNT  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table in RUN, then
// hand-written divide, busywait, mid-divide reset and counter saturation sequences.
module tb_hazard_control_unit;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_S = 7'b0100011;

    // {PC,IFID,IDEX,EXMEM,MEMWB writes, IFID_FLUSH, IDEX_FLUSH, IDEX_BUBBLE, EXMEM_BUBBLE, DIV_ACTIVE}
    localparam logic [9:0] C_ZERO = 10'b00000_0000_0;
    localparam logic [9:0] C_DEF  = 10'b11111_0000_0;
    localparam logic [9:0] C_LU   = 10'b00111_0010_0;
    localparam logic [9:0] C_BR   = 10'b11111_1100_0;
    localparam logic [9:0] C_DENT = 10'b00011_0001_0;
    localparam logic [9:0] C_DSTL = 10'b00011_0001_1;
    localparam logic [9:0] C_DREL = 10'b11111_0000_1;
    localparam logic [9:0] C_FRZD = 10'b00000_0000_1;

    typedef struct {
        logic [4:0] a1;
        logic [4:0] a2;
        logic       u1;
        logic       u2;
        logic [6:0] op;
        logic [4:0] ea;
        logic       mr;
        logic       br;
        logic       ib;
        logic       db;
        logic [9:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [9:0] exp_q[$];
    vec_t vq[$];

    hazard_control_unit_if hif ();
    hazard_control_unit_if hif2 ();

    hazard_control_unit #(.DIV_CYCLES(4)) dut (.CLK(clk), .RESET(rst_n), .hif(hif));
    hazard_control_unit #(.DIV_CYCLES(2)) dut2 (.CLK(clk), .RESET(rst_n), .hif(hif2));

    assign hif2.ADDR1         = hif.ADDR1;
    assign hif2.ADDR2         = hif.ADDR2;
    assign hif2.RS1_USED      = hif.RS1_USED;
    assign hif2.RS2_USED      = hif.RS2_USED;
    assign hif2.OPCODE        = hif.OPCODE;
    assign hif2.EXE_ADDR      = hif.EXE_ADDR;
    assign hif2.EXE_MEMREAD   = hif.EXE_MEMREAD;
    assign hif2.EXE_DIV       = hif.EXE_DIV;
    assign hif2.BRANCH_TAKEN  = hif.BRANCH_TAKEN;
    assign hif2.IMEM_BUSYWAIT = hif.IMEM_BUSYWAIT;
    assign hif2.DMEM_BUSYWAIT = hif.DMEM_BUSYWAIT;

    logic [9:0] ctrl, ctrl2;
    assign ctrl  = {hif.PC_WRITE, hif.IFID_WRITE, hif.IDEX_WRITE, hif.EXMEM_WRITE, hif.MEMWB_WRITE,
                    hif.IFID_FLUSH, hif.IDEX_FLUSH, hif.IDEX_BUBBLE, hif.EXMEM_BUBBLE, hif.DIV_ACTIVE};
    assign ctrl2 = {hif2.PC_WRITE, hif2.IFID_WRITE, hif2.IDEX_WRITE, hif2.EXMEM_WRITE, hif2.MEMWB_WRITE,
                    hif2.IFID_FLUSH, hif2.IDEX_FLUSH, hif2.IDEX_BUBBLE, hif2.EXMEM_BUBBLE, hif2.DIV_ACTIVE};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_idle();
        hif.ADDR1 = 5'd0; hif.ADDR2 = 5'd0; hif.RS1_USED = 1'b0; hif.RS2_USED = 1'b0;
        hif.OPCODE = OP_R; hif.EXE_ADDR = 5'd0; hif.EXE_MEMREAD = 1'b0; hif.EXE_DIV = 1'b0;
        hif.BRANCH_TAKEN = 1'b0; hif.IMEM_BUSYWAIT = 1'b0; hif.DMEM_BUSYWAIT = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        hif.ADDR1 = v.a1; hif.ADDR2 = v.a2; hif.RS1_USED = v.u1; hif.RS2_USED = v.u2;
        hif.OPCODE = v.op; hif.EXE_ADDR = v.ea; hif.EXE_MEMREAD = v.mr; hif.EXE_DIV = 1'b0;
        hif.BRANCH_TAKEN = v.br; hif.IMEM_BUSYWAIT = v.ib; hif.DMEM_BUSYWAIT = v.db;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        hif.EXE_MEMREAD = 1'b1; hif.EXE_ADDR = r; hif.ADDR1 = r; hif.RS1_USED = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input string name, input logic [4:0] a1, input logic [4:0] a2,
                           input logic u1, input logic u2, input logic [6:0] op,
                           input logic [4:0] ea, input logic mr, input logic br,
                           input logic ib, input logic db, input logic [9:0] exp);
        vec_t v;
        v.name = name; v.a1 = a1; v.a2 = a2; v.u1 = u1; v.u2 = u2; v.op = op;
        v.ea = ea; v.mr = mr; v.br = br; v.ib = ib; v.db = db; v.exp = exp;
        vq.push_back(v);
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic [9:0] act, input logic [9:0] exp);
        logic [9:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        check(name, 16'(act), 16'(e));
    endtask

    initial begin
        int exp_stall;
        int exp_flush;
        n_tests = 0;
        n_fail  = 0;
        exp_stall = 0;
        exp_flush = 0;

        //       name               a1 a2 u1 u2 op    ea mr br ib db exp
        add_vec("idle",             0, 0, 0, 0, OP_R, 0, 0, 0, 0, 0, C_DEF);
        add_vec("lu_rs1",           1, 0, 1, 0, OP_R, 1, 1, 0, 0, 0, C_LU);
        add_vec("lu_gone",          1, 0, 1, 0, OP_R, 1, 0, 0, 0, 0, C_DEF);
        add_vec("store_data_rs2",   2, 1, 1, 1, OP_S, 1, 1, 0, 0, 0, C_DEF);
        add_vec("x0_load",          0, 0, 1, 1, OP_R, 0, 1, 0, 0, 0, C_DEF);
        add_vec("lu_rs2",           7, 3, 1, 1, OP_R, 3, 1, 0, 0, 0, C_LU);
        add_vec("rs1_not_used",     5, 0, 0, 0, OP_R, 5, 1, 0, 0, 0, C_DEF);
        add_vec("branch_over_lu",   6, 0, 1, 0, OP_R, 6, 1, 1, 0, 0, C_BR);
        add_vec("imem_over_lu",     6, 0, 1, 0, OP_R, 6, 1, 0, 1, 0, C_ZERO);
        add_vec("dmem_over_branch", 0, 0, 0, 0, OP_R, 0, 0, 1, 0, 1, C_ZERO);
        add_vec("rs2_not_used",     4, 9, 1, 0, OP_R, 9, 1, 0, 0, 0, C_DEF);
        add_vec("store_base_rs1",   8, 2, 1, 1, OP_S, 8, 1, 0, 0, 0, C_LU);

        // Reset state
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        #2;
        check_ctrl("reset_outputs", ctrl, C_ZERO);
        check("reset_stall_count", hif.STALL_COUNT, 16'd0);
        check("reset_flush_count", hif.FLUSH_COUNT, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle table in RUN
        for (int i = 0; i < vq.size(); i++) begin
            drive_vec(vq[i]);
            #2;
            check_ctrl(vq[i].name, ctrl, vq[i].exp);
            if (!vq[i].exp[9]) exp_stall++;
            if (vq[i].exp[4]) exp_flush++;
            @(negedge clk);
        end
        set_idle();
        #2;
        check("table_stall_count", hif.STALL_COUNT, 16'(exp_stall));
        check("table_flush_count", hif.FLUSH_COUNT, 16'(exp_flush));

        // Divide, DIV_CYCLES=4 (dut) and 2 (dut2)
        do_reset();
        hif.EXE_DIV = 1'b1;
        #2;
        check_ctrl("div_entry", ctrl, C_DENT);
        check_ctrl("div2_entry", ctrl2, C_DENT);
        @(negedge clk);
        hif.BRANCH_TAKEN = 1'b1;
        set_load_use(5'd4);
        #2;
        check_ctrl("div_ignores_branch_lu", ctrl, C_DSTL);
        check_ctrl("div2_release", ctrl2, C_DREL);
        @(negedge clk);
        set_idle();
        hif.EXE_DIV = 1'b1;
        #2;
        check_ctrl("div_stall_3", ctrl, C_DSTL);
        @(negedge clk);
        #2;
        check_ctrl("div_release", ctrl, C_DREL);
        @(negedge clk);
        hif.EXE_DIV = 1'b0;
        #2;
        check_ctrl("div_back_to_run", ctrl, C_DEF);
        check("div_stall_count", hif.STALL_COUNT, 16'd3);
        check("div_flush_count", hif.FLUSH_COUNT, 16'd0);

        // Busywait inside DIV_WAIT, then reset mid-divide
        do_reset();
        hif.EXE_DIV = 1'b1;
        #2;
        check_ctrl("bdiv_entry", ctrl, C_DENT);
        @(negedge clk);
        #2;
        check_ctrl("bdiv_stall", ctrl, C_DSTL);
        @(negedge clk);
        hif.DMEM_BUSYWAIT = 1'b1;
        #2;
        check_ctrl("bdiv_frozen_1", ctrl, C_FRZD);
        @(negedge clk);
        #2;
        check_ctrl("bdiv_frozen_2", ctrl, C_FRZD);
        @(negedge clk);
        hif.DMEM_BUSYWAIT = 1'b0;
        #2;
        check_ctrl("bdiv_cnt_held", ctrl, C_DSTL);
        @(negedge clk);
        #2;
        check_ctrl("bdiv_release", ctrl, C_DREL);
        @(negedge clk);
        #2;
        check_ctrl("bdiv_reentry", ctrl, C_DENT);
        check("bdiv_stall_total", hif.STALL_COUNT, 16'd5);
        @(negedge clk);
        #2;
        check_ctrl("bdiv_wait_again", ctrl, C_DSTL);
        check("bdiv_stall_before_rst", hif.STALL_COUNT, 16'd6);
        #1 rst_n = 1'b0;
        #1;
        check_ctrl("midrst_outputs", ctrl, C_ZERO);
        check("midrst_stall_count", hif.STALL_COUNT, 16'd0);
        check("midrst_flush_count", hif.FLUSH_COUNT, 16'd0);
        @(negedge clk);
        #2;
        check_ctrl("midrst_held", ctrl, C_ZERO);
        rst_n = 1'b1;
        hif.EXE_DIV = 1'b0;
        #1;
        check_ctrl("midrst_state_run", ctrl, C_DEF);
        @(negedge clk);

        // Stall counter saturation via instruction-memory freeze
        do_reset();
        hif.IMEM_BUSYWAIT = 1'b1;
        #2;
        check_ctrl("imem_freeze", ctrl, C_ZERO);
        repeat (65534) @(negedge clk);
        #2;
        check("stall_fffe", hif.STALL_COUNT, 16'hFFFE);
        @(negedge clk);
        #2;
        check("stall_ffff", hif.STALL_COUNT, 16'hFFFF);
        repeat (5) @(negedge clk);
        #2;
        check("stall_saturated", hif.STALL_COUNT, 16'hFFFF);
        check("sat_flush_count", hif.FLUSH_COUNT, 16'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
